// File: rtl/lcd_char_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_char_wrap
//  Description : Autonomous HD44780 4-bit character-LCD driver. Runs the
//                power-on nibble initialisation, configures and clears the
//                display, writes a fixed status banner, then idles quietly.
//                Define LCD_SECOND_LINE_EN to also write the second banner line.
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_char_wrap #(
    parameter int T_POWERUP = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_CMD     = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int T_GAP     = 50
) (
    input  logic       clk_50mhz,
    input  logic       rstn,
    output logic [2:0] lcd_ctrl_3bits,
    output logic [3:0] lcd_data_4bits
);

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_CFG   = 3'd2,
        ST_LINE1 = 3'd3,
        ST_LINE2 = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_NIB_HI = 2'd0,
        PH_GAP    = 2'd1,
        PH_NIB_LO = 2'd2,
        PH_WAIT   = 2'd3
    } phase_t;

    localparam logic [19:0] C_POWERUP = 20'(T_POWERUP);
    localparam logic [19:0] C_INIT1   = 20'(T_INIT1);
    localparam logic [19:0] C_INIT2   = 20'(T_INIT2);
    localparam logic [19:0] C_CMD     = 20'(T_CMD);
    localparam logic [19:0] C_CLEAR   = 20'(T_CLEAR);
    localparam logic [19:0] C_GAP     = 20'(T_GAP);

    // 32-character banner ROM: index 0 is the leftmost character of line 1
    localparam logic [255:0] C_BANNER = {"16PU DAQ READY  ", "SiTCP ADC 16CH  "};

    // Byte (or init nibble in the low half) carried by item i of state s
    function automatic logic [7:0] item_byte(state_t s, logic [4:0] i);
        logic [4:0] k;
        k = i - 5'd1 + ((s == ST_LINE2) ? 5'd16 : 5'd0);
        case (s)
            ST_INIT:  item_byte = (i == 5'd3) ? 8'h02 : 8'h03;
            ST_CFG: begin
                case (i[1:0])
                    2'd0:    item_byte = 8'h28;
                    2'd1:    item_byte = 8'h0C;
                    2'd2:    item_byte = 8'h06;
                    default: item_byte = 8'h01;
                endcase
            end
            ST_LINE1: item_byte = (i == 5'd0) ? 8'h80 : C_BANNER[{5'd31 - k, 3'b000} +: 8];
            ST_LINE2: item_byte = (i == 5'd0) ? 8'hC0 : C_BANNER[{5'd31 - k, 3'b000} +: 8];
            default:  item_byte = 8'h00;
        endcase
    endfunction

    // Characters are data writes; every other item is a command
    function automatic logic item_rs(state_t s, logic [4:0] i);
        item_rs = ((s == ST_LINE1) || (s == ST_LINE2)) && (i != 5'd0);
    endfunction

    // Post-item wait length
    function automatic logic [19:0] item_wait(state_t s, logic [4:0] i);
        if (s == ST_INIT)
            item_wait = (i == 5'd0) ? C_INIT1 : C_INIT2;
        else
            item_wait = (item_byte(s, i) == 8'h01) ? C_CLEAR : C_CMD;
    endfunction

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [4:0]  idx_q, idx_d;
    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [3:0]  data_q, data_d;
    logic [4:0]  last_idx;
    logic [7:0]  nib_byte;
    logic        rs_d;
    logic        e_d;

    // Sequencer: walk items within each state, pacing nibbles, gaps and waits
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + 20'd1;
        last_idx = ((state_q == ST_INIT) || (state_q == ST_CFG)) ? 5'd3 : 5'd16;
        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == C_POWERUP - 20'd1) begin
                    state_d = ST_INIT;
                    idx_d   = 5'd0;
                    phase_d = PH_NIB_LO;
                    cnt_d   = 20'd0;
                end
            end
            ST_DONE: begin
                cnt_d = 20'd0;
            end
            default: begin
                case (phase_q)
                    PH_NIB_HI: begin
                        if (cnt_q == 20'd15) begin
                            phase_d = (C_GAP == 20'd0) ? PH_NIB_LO : PH_GAP;
                            cnt_d   = 20'd0;
                        end
                    end
                    PH_GAP: begin
                        if (cnt_q == C_GAP - 20'd1) begin
                            phase_d = PH_NIB_LO;
                            cnt_d   = 20'd0;
                        end
                    end
                    PH_NIB_LO: begin
                        if (cnt_q == 20'd15) begin
                            phase_d = PH_WAIT;
                            cnt_d   = 20'd0;
                        end
                    end
                    default: begin
                        if (cnt_q == item_wait(state_q, idx_q) - 20'd1) begin
                            cnt_d = 20'd0;
                            if (idx_q == last_idx) begin
                                idx_d   = 5'd0;
                                phase_d = PH_NIB_HI;
                                case (state_q)
                                    ST_INIT:  state_d = ST_CFG;
                                    ST_CFG:   state_d = ST_LINE1;
`ifdef LCD_SECOND_LINE_EN
                                    ST_LINE1: state_d = ST_LINE2;
`else
                                    ST_LINE1: state_d = ST_DONE;
`endif
                                    default:  state_d = ST_DONE;
                                endcase
                            end else begin
                                idx_d   = idx_q + 5'd1;
                                phase_d = (state_q == ST_INIT) ? PH_NIB_LO : PH_NIB_HI;
                            end
                        end
                    end
                endcase
            end
        endcase

        // Outputs follow the next sequencer position so they register in step
        nib_byte = item_byte(state_d, idx_d);
        rs_d     = ctrl_q[0];
        data_d   = data_q;
        e_d      = 1'b0;
        if ((state_d == ST_PWRUP) || (state_d == ST_DONE)) begin
            rs_d   = 1'b0;
            data_d = 4'h0;
        end else if ((phase_d == PH_NIB_HI) || (phase_d == PH_NIB_LO)) begin
            rs_d   = item_rs(state_d, idx_d);
            data_d = (phase_d == PH_NIB_HI) ? nib_byte[7:4] : nib_byte[3:0];
            e_d    = (cnt_d >= 20'd2) && (cnt_d <= 20'd13);
        end
        ctrl_d = {e_d, 1'b0, rs_d};
    end

    // State, counters and registered bus outputs
    always_ff @(posedge clk_50mhz or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_PWRUP;
            phase_q <= PH_WAIT;
            idx_q   <= 5'd0;
            cnt_q   <= 20'd0;
            ctrl_q  <= 3'b000;
            data_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign lcd_ctrl_3bits = ctrl_q;
    assign lcd_data_4bits = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_char_wrap
//  Description : Scoreboard bench for lcd_char_wrap with scaled timing.
//                Expected E pulses (RS, nibble, rise cycle) are queued by the
//                stimulus; a monitor pops and compares on every E rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_char_wrap;

    localparam int P_PWR = 100;
    localparam int P_I1  = 40;
    localparam int P_I2  = 20;
    localparam int P_CMD = 30;
    localparam int P_CLR = 60;
    localparam int P_GAP = 5;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         t;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic [2:0] ctrl;
    logic [3:0] data;

    exp_t       exp_q[$];
    exp_t       cur;
    int         errors = 0;
    int         checks = 0;
    int         t_next;
    int         end_t;
    int         cyc = 0;
    int         hi_cnt = 0;
    logic       prev_e = 1'b0;
    logic       rise_rs;
    logic [3:0] rise_d;

    always #5 clk = ~clk;

    lcd_char_wrap #(
        .T_POWERUP (P_PWR),
        .T_INIT1   (P_I1),
        .T_INIT2   (P_I2),
        .T_CMD     (P_CMD),
        .T_CLEAR   (P_CLR),
        .T_GAP     (P_GAP)
    ) dut (
        .clk_50mhz      (clk),
        .rstn           (rstn),
        .lcd_ctrl_3bits (ctrl),
        .lcd_data_4bits (data)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_nib(input logic rs, input logic [3:0] d, input int after);
        exp_t e;
        e.rs = rs;
        e.d  = d;
        e.t  = t_next;
        exp_q.push_back(e);
        t_next += 16 + after;
    endtask

    task automatic push_byte(input logic rs, input logic [7:0] b);
        push_nib(rs, b[7:4], P_GAP);
        push_nib(rs, b[3:0], (b == 8'h01) ? P_CLR : P_CMD);
    endtask

    task automatic build_expect();
        string l1;
        string l2;
        l1 = "16PU DAQ READY  ";
        l2 = "SiTCP ADC 16CH  ";
        exp_q.delete();
        t_next = P_PWR + 2;
        push_nib(1'b0, 4'h3, P_I1);
        push_nib(1'b0, 4'h3, P_I2);
        push_nib(1'b0, 4'h3, P_I2);
        push_nib(1'b0, 4'h2, P_I2);
        push_byte(1'b0, 8'h28);
        push_byte(1'b0, 8'h0C);
        push_byte(1'b0, 8'h06);
        push_byte(1'b0, 8'h01);
        push_byte(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(l1.getc(i)));
`ifdef LCD_SECOND_LINE_EN
        push_byte(1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) push_byte(1'b1, 8'(l2.getc(i)));
`endif
        end_t = t_next;
    endtask

    // Monitor: compare each E pulse against the scoreboard and police its shape
    always @(negedge clk) begin
        if (!rstn) begin
            cyc    = 0;
            prev_e = 1'b0;
            hi_cnt = 0;
        end else begin
            cyc++;
            if (ctrl[2] && !prev_e) begin
                chk("rw_low", int'(ctrl[1]), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_e_pulse", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("pulse_rs", int'(ctrl[0]), int'(cur.rs));
                    chk("pulse_data", int'(data), int'(cur.d));
                    chk("pulse_rise_cycle", cyc, cur.t);
                end
                rise_rs = ctrl[0];
                rise_d  = data;
                hi_cnt  = 1;
            end else if (ctrl[2]) begin
                hi_cnt++;
                chk("rs_stable_while_e", int'(ctrl[0]), int'(rise_rs));
                chk("data_stable_while_e", int'(data), int'(rise_d));
            end else if (prev_e) begin
                chk("e_high_width", hi_cnt, 12);
                chk("rs_hold_after_e", int'(ctrl[0]), int'(rise_rs));
                chk("data_hold_after_e", int'(data), int'(rise_d));
            end
            prev_e = ctrl[2];
        end
    end

    // Stimulus: reset hold, aborted run, full run, then idle observation
    initial begin
        #1 rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("reset_ctrl", int'(ctrl), 0);
            chk("reset_data", int'(data), 0);
        end

        // First run, cut short by reset in the middle of the second E pulse
        build_expect();
        @(negedge clk);
        #1 rstn = 1'b1;
        while (cyc < 160) begin
            @(negedge clk);
            #1;
        end
        chk("e_high_before_abort", int'(ctrl[2]), 1);
        chk("data_before_abort", int'(data), 3);
        #2 rstn = 1'b0;
        #1;
        chk("async_reset_ctrl", int'(ctrl), 0);
        chk("async_reset_data", int'(data), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("reset_hold_ctrl", int'(ctrl), 0);
        end

        // Full run from a fresh release
        build_expect();
        @(negedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < end_t + 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("pulses_outstanding", exp_q.size(), 0);

        while (cyc < end_t) begin
            @(negedge clk);
            #1;
        end
        chk("done_ctrl", int'(ctrl), 0);
        chk("done_data", int'(data), 0);

        repeat (10000) @(negedge clk);
        #1;
        chk("idle_ctrl", int'(ctrl), 0);
        chk("idle_data", int'(data), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
